// File: rtl/fm_pkg.sv
// Shared definitions for the feature-map stream capture block: FSM state
// encoding and frame-geometry helpers used to size counters and addresses.
package fm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } fm_state_e;

   function automatic int fm_depth(input int width, input int height);
      return width * height;
   endfunction

   function automatic int fm_addr_w(input int depth);
      return (depth < 32'sd2) ? 32'sd1 : $clog2(depth);
   endfunction

   // Counters get headroom past n so they can saturate on a value that never equals n.
   function automatic int fm_cnt_w(input int n);
      return $clog2(n + 32'sd2);
   endfunction

endpackage

// File: rtl/fm_capture_ram.sv
// Simple dual-port frame store: one synchronous write port and one registered
// read port on the same clock. Contents are not reset; only the read register is.
module fm_capture_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_zero,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rd_data_r;

   // write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // registered read port; out-of-range reads return zero, idle cycles hold the last word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_r <= {DATA_W{1'b0}};
      end else if (rd_en) begin
         if (rd_zero) begin
            rd_data_r <= {DATA_W{1'b0}};
         end else begin
            rd_data_r <= mem_r[rd_addr];
         end
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/fm_stream_capture.sv
// Captures one vsync/href framed feature map into a local RAM in raster order and
// flags geometry errors. Define FM_CAPTURE_RELU_EN to store negative pixels as zero.
module fm_stream_capture
   import fm_pkg::*;
#(
   parameter int  FM_WIDTH  = 4,
   parameter int  FM_HEIGHT = 4,
   parameter int  DATA_W    = 16,
   localparam int DEPTH     = fm_depth(FM_WIDTH, FM_HEIGHT),
   localparam int ADDR_W    = fm_addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture_start,
   output logic              start_output,
   input  logic              in_vsync,
   input  logic              in_href,
   input  logic [DATA_W-1:0] in_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              frame_done,
   output logic              geom_err
);

   localparam int WA_W = $clog2(DEPTH + 32'sd1);
   localparam int HC_W = fm_cnt_w(FM_WIDTH);
   localparam int VC_W = fm_cnt_w(FM_HEIGHT);
   localparam logic [WA_W-1:0]   DEPTH_WA = WA_W'(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_RA = (ADDR_W + 1)'(DEPTH);
   localparam logic [HC_W-1:0]   WIDTH_H  = HC_W'(FM_WIDTH);
   localparam logic [VC_W-1:0]   HEIGHT_V = VC_W'(FM_HEIGHT);

   fm_state_e         state_r;
   logic              vsync_d_r;
   logic              href_d_r;
   logic [WA_W-1:0]   wr_addr_r;
   logic [HC_W-1:0]   h_cnt_r;
   logic [VC_W-1:0]   v_cnt_r;
   logic              start_output_r;
   logic              busy_r;
   logic              frame_done_r;
   logic              geom_err_r;
   logic              rd_valid_r;

   logic              pix_valid_s;
   logic              vs_rise_s;
   logic              vs_fall_s;
   logic              href_fall_s;
   logic              take_pix_s;
   logic              close_line_s;
   logic              wr_en_s;
   logic [VC_W-1:0]   v_next_s;
   logic              rd_fire_s;
   logic              rd_zero_s;
   logic [DATA_W-1:0] wr_data_s;

`ifdef FM_CAPTURE_RELU_EN
   assign wr_data_s = in_data[DATA_W-1] ? {DATA_W{1'b0}} : in_data;
`else
   assign wr_data_s = in_data;
`endif

   // edge detection, pixel acceptance and line/frame closing decisions
   always_comb begin
      pix_valid_s  = in_vsync & in_href;
      vs_rise_s    = in_vsync & ~vsync_d_r;
      vs_fall_s    = ~in_vsync & vsync_d_r;
      href_fall_s  = ~in_href & href_d_r;
      take_pix_s   = 1'b0;
      close_line_s = 1'b0;
      case (state_r)
         ST_ARMED: begin
            take_pix_s = pix_valid_s & vs_rise_s;
         end
         ST_CAPTURE: begin
            take_pix_s   = pix_valid_s;
            // a line still open when vsync drops is closed and checked like any other
            close_line_s = href_fall_s | (vs_fall_s & href_d_r);
         end
         default: begin
            take_pix_s   = 1'b0;
            close_line_s = 1'b0;
         end
      endcase
      wr_en_s = take_pix_s & (wr_addr_r < DEPTH_WA);
      if (close_line_s && (v_cnt_r != {VC_W{1'b1}})) begin
         v_next_s = v_cnt_r + VC_W'(1'b1);
      end else begin
         v_next_s = v_cnt_r;
      end
      rd_fire_s = rd_en & (state_r == ST_IDLE);
      rd_zero_s = ({1'b0, rd_addr} >= DEPTH_RA);
   end

   // capture FSM with its counters and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         vsync_d_r      <= 1'b0;
         href_d_r       <= 1'b0;
         wr_addr_r      <= {WA_W{1'b0}};
         h_cnt_r        <= {HC_W{1'b0}};
         v_cnt_r        <= {VC_W{1'b0}};
         start_output_r <= 1'b0;
         busy_r         <= 1'b0;
         frame_done_r   <= 1'b0;
         geom_err_r     <= 1'b0;
         rd_valid_r     <= 1'b0;
      end else begin
         vsync_d_r      <= in_vsync;
         href_d_r       <= in_href;
         start_output_r <= 1'b0;
         frame_done_r   <= 1'b0;
         rd_valid_r     <= rd_fire_s;
         if (take_pix_s) begin
            if (h_cnt_r != {HC_W{1'b1}}) begin
               h_cnt_r <= h_cnt_r + HC_W'(1'b1);
            end
            // wr_addr parks at DEPTH so every later pixel is dropped and flagged
            if (wr_en_s) begin
               wr_addr_r <= wr_addr_r + WA_W'(1'b1);
            end else begin
               geom_err_r <= 1'b1;
            end
         end
         if (close_line_s) begin
            if (h_cnt_r != WIDTH_H) begin
               geom_err_r <= 1'b1;
            end
            h_cnt_r <= {HC_W{1'b0}};
            v_cnt_r <= v_next_s;
         end
         case (state_r)
            ST_IDLE: begin
               if (capture_start) begin
                  state_r        <= ST_ARMED;
                  start_output_r <= 1'b1;
                  busy_r         <= 1'b1;
                  geom_err_r     <= 1'b0;
                  wr_addr_r      <= {WA_W{1'b0}};
                  h_cnt_r        <= {HC_W{1'b0}};
                  v_cnt_r        <= {VC_W{1'b0}};
               end
            end
            ST_ARMED: begin
               if (vs_rise_s) begin
                  state_r <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (vs_fall_s) begin
                  if (v_next_s != HEIGHT_V) begin
                     geom_err_r <= 1'b1;
                  end
                  state_r      <= ST_DONE;
                  busy_r       <= 1'b0;
                  frame_done_r <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   fm_capture_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s),
      .wr_addr (wr_addr_r[ADDR_W-1:0]),
      .wr_data (wr_data_s),
      .rd_en   (rd_fire_s),
      .rd_zero (rd_zero_s),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign start_output = start_output_r;
   assign rd_valid     = rd_valid_r;
   assign busy         = busy_r;
   assign frame_done   = frame_done_r;
   assign geom_err     = geom_err_r;

endmodule

// File: tb/tb_fm_stream_capture.sv
// Bench for fm_stream_capture: directed frames plus randomized frames and reads,
// compared every cycle against a frame-level reference model.
module tb_fm_stream_capture;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 16;
   localparam int D  = W * H;
   localparam int AW = 4;

   logic          clk           = 1'b0;
   logic          rst           = 1'b1;
   logic          capture_start = 1'b0;
   logic          in_vsync      = 1'b0;
   logic          in_href       = 1'b0;
   logic [DW-1:0] in_data       = '0;
   logic          rd_en         = 1'b0;
   logic [AW-1:0] rd_addr       = '0;
   logic          start_output, rd_valid, busy, frame_done, geom_err;
   logic [DW-1:0] rd_data;

   int n_checks  = 0;
   int n_errors  = 0;
   int done_cnt  = 0;
   int start_cnt = 0;
   int data_mode = 0;
   logic [DW-1:0] data_base = '0;
   bit rnd_rd = 1'b0;

   fm_stream_capture #(.FM_WIDTH(W), .FM_HEIGHT(H), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .capture_start(capture_start), .start_output(start_output),
      .in_vsync(in_vsync), .in_href(in_href), .in_data(in_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .busy(busy), .frame_done(frame_done), .geom_err(geom_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] mem_m [D];
   bit known_m [D];
   int mode_m = 0;   // 0 idle, 1 armed, 2 capturing, 3 done
   int line_m = 0, lines_m = 0, pix_m = 0;
   bit vs_q = 0, hr_q = 0;
   bit e_start = 0, e_busy = 0, e_done = 0, e_err = 0, e_rv = 0, e_rd_known = 1;
   logic [DW-1:0] e_rd = '0;

   function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef FM_CAPTURE_RELU_EN
      return ($signed(d) < 0) ? '0 : d;
`else
      return d;
`endif
   endfunction

   task automatic model_pixel();
      if (pix_m < D) begin
         mem_m[pix_m]   = stored(in_data);
         known_m[pix_m] = 1'b1;
      end else begin
         e_err = 1'b1;
      end
      pix_m++;
      line_m++;
   endtask

   task automatic model_edge();
      bit pix, vrise, vfall, close;
      pix   = in_vsync && in_href;
      vrise = in_vsync && !vs_q;
      vfall = !in_vsync && vs_q;
      e_start = 1'b0;
      e_done  = 1'b0;
      e_rv    = 1'b0;
      case (mode_m)
         0: begin
            if (rd_en) begin
               e_rv = 1'b1;
               if (int'(rd_addr) >= D) begin
                  e_rd = '0;
                  e_rd_known = 1'b1;
               end else begin
                  e_rd = mem_m[rd_addr];
                  e_rd_known = known_m[rd_addr];
               end
            end
            if (capture_start) begin
               mode_m = 1; e_start = 1'b1; e_busy = 1'b1; e_err = 1'b0;
               line_m = 0; lines_m = 0; pix_m = 0;
            end
         end
         1: begin
            if (vrise) begin
               mode_m = 2;
               if (pix) model_pixel();
            end
         end
         2: begin
            if (pix) model_pixel();
            close = hr_q && (!in_href || !in_vsync);
            if (close) begin
               if (line_m != W) e_err = 1'b1;
               line_m = 0;
               lines_m++;
            end
            if (vfall) begin
               if (lines_m != H) e_err = 1'b1;
               mode_m = 3; e_done = 1'b1; e_busy = 1'b0;
            end
         end
         default: mode_m = 0;
      endcase
      vs_q = in_vsync;
      hr_q = in_href;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mode_m = 0; line_m = 0; lines_m = 0; pix_m = 0; vs_q = 0; hr_q = 0;
            e_start = 0; e_busy = 0; e_done = 0; e_err = 0; e_rv = 0;
            e_rd = '0; e_rd_known = 1'b1;
         end else begin
            model_edge();
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk("start_output", start_output, e_start);
         chk("busy", busy, e_busy);
         chk("frame_done", frame_done, e_done);
         chk("geom_err", geom_err, e_err);
         chk("rd_valid", rd_valid, e_rv);
         if (e_rd_known) chk("rd_data", rd_data, e_rd);
         if (frame_done === 1'b1) done_cnt++;
         if (start_output === 1'b1) start_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rd) begin
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = AW'($urandom);
      end
   endtask

   function automatic logic [DW-1:0] pick_data(input int k);
      case (data_mode)
         1: return DW'($urandom);
         2: return (k == 0) ? 16'h8001 : (k == 1) ? 16'h0005 : data_base + DW'(k);
         default: return data_base + DW'(k);
      endcase
   endfunction

   task automatic arm();
      capture_start = 1'b1;
      tick();
      capture_start = 1'b0;
   endtask

   task automatic send_frame(input int nlines, input int short_idx, input int gap,
                             input bit rnd, input bit keep_href, input int collide_line);
      int k = 0;
      int len;
      int g;
      in_vsync = 1'b1;
      tick();
      tick();
      for (int l = 0; l < nlines; l++) begin
         len = (l == short_idx) ? W - 1 : W;
         if (rnd && $urandom_range(0, 5) == 0) len = W - 1 + int'($urandom_range(0, 2));
         in_href = 1'b1;
         for (int p = 0; p < len; p++) begin
            in_data = pick_data(k);
            k++;
            if (l == collide_line && p == 0) begin
               capture_start = 1'b1; rd_en = 1'b1; rd_addr = '0;
            end else begin
               capture_start = rnd && ($urandom_range(0, 7) == 0);
            end
            tick();
            if (l == collide_line && p == 0) begin
               capture_start = 1'b0; rd_en = 1'b0;
               @(negedge clk);
               chk("collide_rd_valid", rd_valid, 0);
               chk("collide_start", start_output, 0);
               chk("collide_busy", busy, 1);
            end
         end
         capture_start = 1'b0;
         if (keep_href && l == nlines - 1) break;
         in_href = 1'b0;
         tick();
         if (l == short_idx) begin
            @(negedge clk);
            chk("short_line_err", geom_err, 1);
         end
         g = rnd ? int'($urandom_range(1, 6)) : gap;
         for (int i = 1; i < g; i++) tick();
      end
      in_vsync = 1'b0;
      tick();
      in_href = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic read_lit(input int a, input logic [DW-1:0] exp, input string nm);
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      tick();
      rd_en = 1'b0;
      @(negedge clk);
      chk("rd_valid_lit", rd_valid, 1);
      chk(nm, rd_data, exp);
   endtask

   initial begin
      int s0, d0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_start", start_output, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", geom_err, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      tick();
      rst = 1'b0;
      tick();

      // nominal 4x4 frame, data 0..15, 15-cycle line gaps
      data_mode = 0; data_base = 16'h0000;
      s0 = start_cnt; d0 = done_cnt;
      arm();
      @(negedge clk);
      chk("nom_start_pulse", start_output, 1);
      chk("nom_busy", busy, 1);
      send_frame(H, -1, 15, 1'b0, 1'b0, -1);
      chk("nom_start_count", start_cnt - s0, 1);
      chk("nom_done_count", done_cnt - d0, 1);
      chk("nom_err", geom_err, 0);
      for (int i = 0; i < D; i++) read_lit(i, DW'(i), "nom_read");

      // short second line
      d0 = done_cnt;
      arm();
      send_frame(H, 1, 15, 1'b0, 1'b0, -1);
      chk("short_done_count", done_cnt - d0, 1);
      repeat (5) tick();
      chk("short_err_held", geom_err, 1);
      arm();
      @(negedge clk);
      chk("short_err_cleared", geom_err, 0);

      // five lines: pixels 16..19 must be dropped (capture already armed above)
      data_base = 16'h0100;
      send_frame(H + 1, -1, 3, 1'b0, 1'b0, -1);
      chk("ovf_err", geom_err, 1);
      for (int i = 0; i < D; i++) read_lit(i, 16'h0100 + DW'(i), "ovf_read");

      // reset after six pixels
      arm();
      in_vsync = 1'b1;
      tick();
      tick();
      in_href = 1'b1;
      for (int p = 0; p < 6; p++) begin
         in_data = 16'h0aa0 + DW'(p);
         tick();
      end
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", frame_done, 0);
      tick();
      rst = 1'b0; in_vsync = 1'b0; in_href = 1'b0;
      d0 = done_cnt;
      repeat (5) tick();
      chk("midrst_no_done", done_cnt - d0, 0);
      data_base = 16'h0200;
      arm();
      send_frame(H, -1, 4, 1'b0, 1'b0, 2);
      chk("after_rst_err", geom_err, 0);
      chk("after_rst_done", done_cnt - d0, 1);
      read_lit(5, 16'h0205, "after_rst_read5");
      read_lit(15, 16'h020f, "after_rst_read15");

      // sign handling of stored pixels
      data_mode = 2; data_base = 16'h0000;
      arm();
      send_frame(H, -1, 2, 1'b0, 1'b0, -1);
`ifdef FM_CAPTURE_RELU_EN
      read_lit(0, 16'h0000, "relu_neg");
`else
      read_lit(0, 16'h8001, "relu_neg");
`endif
      read_lit(1, 16'h0005, "relu_pos");
      read_lit(2, 16'h0002, "relu_plain");

      // randomized frames with random reads and stray capture_start pulses
      data_mode = 1;
      rnd_rd = 1'b1;
      for (int f = 0; f < 16; f++) begin
         arm();
         send_frame(int'($urandom_range(3, 5)), -1, 0, 1'b1, 1'(($urandom_range(0, 1))), -1);
         repeat ($urandom_range(2, 10)) tick();
      end
      rnd_rd = 1'b0;
      rd_en  = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
